// File: rtl/mux_nto1_rr_pkg.sv
// Shared constants and the rotating-priority search used by the N-to-1 operand mux.
// The search is sized for the largest supported channel count (16).
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Returns {found, index}: first set bit of req scanning ptr, ptr+1, ... wrapping at nch.
  function automatic logic [4:0] rr_search(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  nch);
    logic       found;
    logic [3:0] idx;
    logic [4:0] j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 16; k++) begin
      j = {1'b0, ptr} + 5'(k);
      if (j >= nch) j = j - nch;
      if (!found && (5'(k) < nch) && req[j[3:0]]) begin
        found = 1'b1;
        idx   = j[3:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Channel-side and output-side handshake bundle for mux_nto1_rr.
// master drives the inputs and downstream ready; slave is the mux itself.
interface mux_nto1_rr_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping at NCH. The pointer register lives in the parent.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  logic [4:0] res;

  assign res     = rr_search(16'(req), 4'(ptr), 5'(NCH));
  assign gnt_vld = res[4];
  assign gnt_idx = SELW'(res[3:0]);

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 operand mux with a single registered output stage, fixed-select or
// round-robin channel choice, and valid/ready on every channel.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input logic          clk,
  input logic          rst_n,
  mux_nto1_rr_if.slave bus
);

  logic            load;
  logic            fix_vld;
  logic            rr_vld;
  logic            gnt_vld;
  logic            xfer;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] gnt_idx;
  logic [NCH-1:0]  ready;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // The output register may refill in the same cycle it drains.
  assign load    = !bus.out_valid || bus.out_ready;
  assign fix_vld = (32'(bus.sel) < NCH) ? bus.in_valid[bus.sel] : 1'b0;
  assign gnt_vld = (bus.mode == MODE_RR) ? rr_vld : fix_vld;
  assign gnt_idx = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
  assign xfer    = rst_n && load && gnt_vld;
  assign ptr_nxt = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + SELW'(1);

  always_comb begin
    ready = '0;
    if (xfer) ready[gnt_idx] = 1'b1;
  end

  assign bus.in_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
      bus.out_ch    <= gnt_idx;
      if (bus.mode == MODE_RR) ptr <= ptr_nxt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: directed scenarios plus a randomized run, all checked
// against a rule-level model of the output beat and round-robin pointer.
module tb_mux_nto1_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic clk;
  logic rst_n;
  int   nchk;
  int   npass;

  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;

  mux_nto1_rr_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  mux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel chosen by the rules for the current inputs, or -1 for none.
  function automatic int exp_grant();
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int off = 0; off < NCH; off++) begin
      int c;
      c = (m_ptr + off) % NCH;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (!rst_n) return 4'b0000;
    g = exp_grant();
    if (g >= 0 && (!m_valid || bus.out_ready)) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 2'd0;
    m_ptr   = 0;
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    bus.in_data = {d, c, b, a};
  endtask

  // Advance one clock and move the model to the state the rules predict.
  task automatic tick();
    int         g;
    logic       ld;
    logic       md;
    logic       ordy;
    logic [7:0] d;
    g    = exp_grant();
    ld   = !m_valid || bus.out_ready;
    md   = bus.mode;
    ordy = bus.out_ready;
    d    = (g >= 0) ? bus.in_data[g*8 +: 8] : 8'h00;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else if (g >= 0 && ld) begin
      m_valid = 1'b1;
      m_data  = d;
      m_ch    = 2'(g);
      if (md) m_ptr = (g + 1) % NCH;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 4'hF;
    bus.mode     = 1'b0;
    bus.sel      = 2'd0;
    bus.out_ready = 1'b1;
    set_data(8'hAA, 8'h55, 8'hCC, 8'h33);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    else npass++;
    nchk++;
    if (bus.out_data !== 8'h00 || bus.out_ch !== 2'd0)
      $display("[TB] FAIL reset_out_regs got=%h/%0d exp=00/0", bus.out_data, bus.out_ch);
    else npass++;
    nchk++;
    if (bus.in_ready !== 4'b0000) $display("[TB] FAIL reset_in_ready got=%b exp=0000", bus.in_ready);
    else npass++;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    logic [7:0] tbl [4];
    tbl = '{8'hAA, 8'h55, 8'hCC, 8'h33};
    bus.mode = 1'b0;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sel = 2'(i);
      #1;
      nchk++;
      if (bus.in_ready !== exp_ready()) $display("[TB] FAIL fixed_in_ready got=%b exp=%b", bus.in_ready, exp_ready());
      else npass++;
      tick();
      nchk++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== tbl[i] || bus.out_ch !== 2'(i))
        $display("[TB] FAIL fixed_beat got=%b/%h/%0d exp=1/%h/%0d", bus.out_valid, bus.out_data, bus.out_ch, tbl[i], i);
      else npass++;
    end
  endtask

  task automatic test_rr_all();
    int seq [6];
    seq = '{0, 1, 2, 3, 0, 1};
    bus.mode = 1'b1;
    bus.in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      nchk++;
      if (bus.in_ready !== 4'(1 << seq[i]) || bus.in_ready !== exp_ready())
        $display("[TB] FAIL rr_all_in_ready got=%b exp=%b", bus.in_ready, 4'(1 << seq[i]));
      else npass++;
      tick();
      nchk++;
      if (bus.out_ch !== 2'(seq[i]) || bus.out_data !== m_data)
        $display("[TB] FAIL rr_all_ch got=%0d/%h exp=%0d/%h", bus.out_ch, bus.out_data, seq[i], m_data);
      else npass++;
    end
  endtask

  task automatic test_rr_sparse();
    int seq [4];
    seq = '{3, 1, 3, 1};
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      nchk++;
      if (bus.in_ready[0] !== 1'b0 || bus.in_ready[2] !== 1'b0 || bus.in_ready !== exp_ready())
        $display("[TB] FAIL rr_sparse_in_ready got=%b exp=%b", bus.in_ready, exp_ready());
      else npass++;
      tick();
      nchk++;
      if (bus.out_ch !== 2'(seq[i])) $display("[TB] FAIL rr_sparse_ch got=%0d exp=%0d", bus.out_ch, seq[i]);
      else npass++;
    end
  endtask

  task automatic test_back_pressure();
    bus.mode = 1'b0;
    bus.sel = 2'd2;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data  = $urandom;
      bus.sel      = 2'($urandom_range(0, 3));
      bus.in_valid = 4'($urandom_range(1, 15));
      #1;
      nchk++;
      if (bus.in_ready !== 4'b0000) $display("[TB] FAIL bp_in_ready got=%b exp=0000", bus.in_ready);
      else npass++;
      nchk++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hCC || bus.out_ch !== 2'd2)
        $display("[TB] FAIL bp_hold got=%b/%h/%0d exp=1/cc/2", bus.out_valid, bus.out_data, bus.out_ch);
      else npass++;
      tick();
    end
    set_data(8'hAA, 8'h55, 8'hCC, 8'h33);
    bus.sel = 2'd3;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    nchk++;
    if (bus.in_ready !== 4'b1000) $display("[TB] FAIL bp_release_ready got=%b exp=1000", bus.in_ready);
    else npass++;
    tick();
    nchk++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33)
      $display("[TB] FAIL bp_release_beat got=%b/%h exp=1/33", bus.out_valid, bus.out_data);
    else npass++;
  endtask

  task automatic test_missing_valid();
    bus.sel = 2'd2;
    bus.in_valid = 4'b1011;
    #1;
    nchk++;
    if (bus.in_ready !== 4'b0000) $display("[TB] FAIL miss_in_ready got=%b exp=0000", bus.in_ready);
    else npass++;
    tick();
    nchk++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h33)
      $display("[TB] FAIL miss_drain got=%b/%h exp=0/33", bus.out_valid, bus.out_data);
    else npass++;
    bus.in_valid = 4'hF;
    #1;
    tick();
    nchk++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hCC || bus.out_ch !== 2'd2)
      $display("[TB] FAIL miss_late_beat got=%b/%h/%0d exp=1/cc/2", bus.out_valid, bus.out_data, bus.out_ch);
    else npass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.mode      = 1'($urandom_range(0, 1));
      bus.sel       = 2'($urandom_range(0, 3));
      bus.in_valid  = 4'($urandom);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      nchk++;
      if (bus.in_ready !== exp_ready()) $display("[TB] FAIL rand_in_ready got=%b exp=%b", bus.in_ready, exp_ready());
      else npass++;
      tick();
      nchk++;
      if ({bus.out_valid, bus.out_ch, bus.out_data} !== {m_valid, m_ch, m_data})
        $display("[TB] FAIL rand_beat got=%b/%0d/%h exp=%b/%0d/%h",
                 bus.out_valid, bus.out_ch, bus.out_data, m_valid, m_ch, m_data);
      else npass++;
    end
  endtask

  task automatic test_reset_async();
    set_data(8'hAA, 8'h55, 8'hCC, 8'h33);
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    nchk++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 4'b0000)
      $display("[TB] FAIL async_reset got=%b/%h/%b exp=0/00/0000", bus.out_valid, bus.out_data, bus.in_ready);
    else npass++;
    tick();
    rst_n = 1'b1;
    bus.mode = 1'b1;
    bus.in_valid = 4'b1100;
    #1;
    nchk++;
    if (bus.in_ready !== 4'b0100) $display("[TB] FAIL post_reset_ready got=%b exp=0100", bus.in_ready);
    else npass++;
    tick();
    nchk++;
    if (bus.out_ch !== 2'd2 || bus.out_data !== 8'hCC)
      $display("[TB] FAIL post_reset_grant got=%0d/%h exp=2/cc", bus.out_ch, bus.out_data);
    else npass++;
  endtask

  initial begin
    nchk = 0;
    npass = 0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_back_pressure();
    test_missing_valid();
    test_random();
    test_reset_async();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised successor to the ALU operand 4-to-1 8-bit mux. Selects one of NCH WIDTH-bit input channels and forwards it through a registered output stage with valid/ready handshakes.
- Two selection modes: fixed select (the legacy mux behaviour, now registered) and round-robin arbitration across all requesting channels.
- Sits between the operand sources and the ALU input register.

Parameters:
- WIDTH, 8, data width per channel in bits
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), width of select and channel-id fields (derived; do not override)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel data valid
- in_ready  out  NCH  per-channel accept; a transfer occurs on in_valid[i] & in_ready[i]
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- out_data  out  WIDTH  registered selected data
- out_ch  out  SELW  index of the channel that produced out_data
- out_valid  out  1  output holds a valid beat
- out_ready  in  1  downstream accept

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready is all-zero while rst_n=0.
- Load condition: load = !out_valid | out_ready. The single output register may refill in the same cycle it drains, giving full throughput of 1 beat/cycle.
- Grant, combinational, at most one bit set:
  - mode=0: grant=sel if in_valid[sel]=1, else none. If sel>=NCH (non-power-of-2 NCH): none.
  - mode=1: first i with in_valid[i]=1, scanning ptr, ptr+1, ... NCH-1, 0, ... ptr-1.
- in_ready[i] = load & grant==i. in_ready never depends on in_valid of the same channel other than through the grant.
- On any input transfer:
  - out_data <= channel data, out_ch <= grant, out_valid <= 1.
  - In mode 1, ptr <= (grant+1) mod NCH, wrapping at NCH rather than 2^SELW.
- No input transfer and out_ready=1: out_valid <= 0; out_data and out_ch hold their values.
- Latency: input beat appears on out_* exactly 1 cycle after its transfer.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_ch/out_valid are stable and all in_ready=0.
- Mode or sel change mid-stream: affects only the next grant. A held output beat is not altered. ptr is not updated in mode 0.
- No valid inputs: no grant, in_ready all 0, output drains normally.
- Reset mid-stream: any held beat is dropped and ptr returns to 0.

Decomposition:
- Package mux_pkg: MODE_FIXED=1'b0 and MODE_RR=1'b1 constants, plus a function for the rotate-priority search.
- Sub-module rr_arbiter: parameter NCH; inputs req[NCH], ptr; outputs gnt_vld, gnt_idx. Purely combinational. Instantiated once; ptr register kept in mux_nto1_rr.

Test Plan:
- Fixed mode, NCH=4, WIDTH=8, inputs A=0xAA, B=0x55, C=0xCC, D=0x33 all valid, out_ready=1, sel stepped 0,1,2,3 -> out_data 0xAA,0x55,0xCC,0x33 one cycle after each sel, with out_ch 0..3.
- Round-robin, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1; in_ready one-hot rotating each cycle.
- Round-robin, only channels 1 and 3 valid, ptr=2 after reset sequence -> grants 3,1,3,1; channel 0 and 2 in_ready stay 0.
- Backpressure: beat 0xCC held with out_ready=0 for 5 cycles while inputs change -> out_data=0xCC and out_valid=1 stable, in_ready=0. Release -> next beat follows in 1 cycle with no gap.
- Fixed mode, sel=2 with in_valid[2]=0 and others valid -> no transfer, out_valid falls after drain. Assert in_valid[2] -> 0xCC appears next cycle.
- Assert rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0 and out_data=0 immediately. After release in mode 1, the first grant goes to the lowest valid index from 0.
